// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, CTRL field
// positions, stop-length encodings and frame configuration payload.
// Optional feature macro: UART_LOOPBACK_EN (adds CTRL[16] loopback bit).
package uart_pkg;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned DVSR_W      = 11;
    localparam int unsigned TICK_CNT_W  = 6;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_W   = 3;

`ifdef UART_LOOPBACK_EN
    localparam int unsigned CTRL_W      = 17;
`else
    localparam int unsigned CTRL_W      = 16;
`endif

    // CTRL field positions
    localparam int unsigned CTRL_DVSR_LSB = 0;
    localparam int unsigned CTRL_DVSR_MSB = 10;
    localparam int unsigned CTRL_STOP_LSB = 13;
    localparam int unsigned CTRL_STOP_MSB = 14;
    localparam int unsigned CTRL_DBITS7   = 15;
    localparam int unsigned CTRL_LOOPBACK = 16;

    typedef enum logic [REG_ADDR_W-1:0] {
        REG_CTRL  = 5'd0,
        REG_READ  = 5'd2,
        REG_WRITE = 5'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        STOP_1     = 2'b00,
        STOP_1P5   = 2'b01,
        STOP_2     = 2'b10,
        STOP_2_ALT = 2'b11
    } stop_sel_e;

    localparam logic [TICK_CNT_W-1:0] STOP_TICKS_1   = 6'd16;
    localparam logic [TICK_CNT_W-1:0] STOP_TICKS_1P5 = 6'd24;
    localparam logic [TICK_CNT_W-1:0] STOP_TICKS_2   = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } frame_state_e;

    // Per-frame configuration captured at frame start
    typedef struct packed {
        logic [TICK_CNT_W-1:0] stop_ticks;
        logic                  dbits7;
    } frame_cfg_t;

    // Stop length in oversample ticks; encoding 11 behaves as 2 stop bits
    function automatic logic [TICK_CNT_W-1:0] stop_ticks(input stop_sel_e sel);
        case (sel)
            STOP_1:   return STOP_TICKS_1;
            STOP_1P5: return STOP_TICKS_1P5;
            default:  return STOP_TICKS_2;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Pointer-based FIFO with registered full/empty flags and a combinational head.
module uart_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_c,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_inc_c;
    logic [ADDR_W-1:0] rd_ptr_inc_c;
    logic              push_ok_c;
    logic              pop_ok_c;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push
    assign pop_ok_c     = pop & ~empty;
    assign push_ok_c    = push & (~full | pop);
    assign wr_ptr_inc_c = wr_ptr_q + ADDR_W'(1);
    assign rd_ptr_inc_c = rd_ptr_q + ADDR_W'(1);
    assign head_c       = mem_q[rd_ptr_q];

    // Storage array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_inc_c;
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_inc_c;
            end
            if (push_ok_c && !pop_ok_c) begin
                empty <= 1'b0;
                full  <= (wr_ptr_inc_c == rd_ptr_q);
            end else if (pop_ok_c && !push_ok_c) begin
                full  <= 1'b0;
                empty <= (rd_ptr_inc_c == wr_ptr_q);
            end
        end
    end

endmodule

// File: rtl/uart_core.sv
// Memory-mapped UART: baud tick generator, tx/rx framers and two byte FIFOs.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[16] routes tx back into rx).
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    input  logic        rx
);

    logic [CTRL_W-1:0]     ctrl_q;
    logic                  wr_ctrl_c;
    logic                  tx_push_c;
    logic                  rx_pop_c;
    logic [DVSR_W-1:0]     dvsr_c;
    logic [DVSR_W-1:0]     baud_cnt_q;
    logic                  tick_c;
    frame_cfg_t            cfg_c;

    logic                  tx_full;
    logic                  tx_empty;
    logic [BYTE_W-1:0]     tx_head_c;
    logic                  tx_pop_c;
    logic                  rx_full;
    logic                  rx_empty;
    logic [BYTE_W-1:0]     rx_head_c;
    logic                  rx_push_c;
    logic [BYTE_W-1:0]     rx_word_c;

    logic                  rx_src_c;
    logic [1:0]            rx_sync_q;
    logic                  rx_in_c;

    frame_state_e          tx_state_q, tx_state_n;
    logic [TICK_CNT_W-1:0] tx_s_q, tx_s_n;
    logic [BIT_CNT_W-1:0]  tx_n_q, tx_n_n;
    logic [BYTE_W-1:0]     tx_b_q, tx_b_n;
    frame_cfg_t            tx_cfg_q, tx_cfg_n;
    logic                  tx_bit_n;
    logic [BIT_CNT_W-1:0]  tx_last_c;

    frame_state_e          rx_state_q, rx_state_n;
    logic [TICK_CNT_W-1:0] rx_s_q, rx_s_n;
    logic [BIT_CNT_W-1:0]  rx_n_q, rx_n_n;
    logic [BYTE_W-1:0]     rx_b_q, rx_b_n;
    frame_cfg_t            rx_cfg_q, rx_cfg_n;
    logic [BIT_CNT_W-1:0]  rx_last_c;

    logic                  unused_c;

    assign unused_c = &{1'b0, wr_data[31:CTRL_W], ctrl_q[CTRL_STOP_LSB-1:CTRL_DVSR_MSB+1], rx_full};

    // Bus decode
    assign wr_ctrl_c = cs & write & (reg_addr == REG_CTRL);
    assign rx_pop_c  = cs & read  & (reg_addr == REG_READ);
    assign tx_push_c = cs & write & (reg_addr == REG_WRITE);
    assign rd_data   = {22'b0, tx_full, rx_empty, rx_head_c};

    // CTRL register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else if (wr_ctrl_c) begin
            ctrl_q <= wr_data[CTRL_W-1:0];
        end
    end

    assign dvsr_c           = ctrl_q[CTRL_DVSR_MSB:CTRL_DVSR_LSB];
    assign cfg_c.stop_ticks = stop_ticks(stop_sel_e'(ctrl_q[CTRL_STOP_MSB:CTRL_STOP_LSB]));
    assign cfg_c.dbits7     = ctrl_q[CTRL_DBITS7];

    // Baud generator: one tick every dvsr+1 clocks
    assign tick_c = (baud_cnt_q == dvsr_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= tick_c ? '0 : baud_cnt_q + DVSR_W'(1);
        end
    end

    uart_fifo #(.DATA_W(BYTE_W), .ADDR_W(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push_c),
        .pop       (tx_pop_c),
        .push_data (wr_data[BYTE_W-1:0]),
        .head_c    (tx_head_c),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_fifo #(.DATA_W(BYTE_W), .ADDR_W(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push_c),
        .pop       (rx_pop_c),
        .push_data (rx_word_c),
        .head_c    (rx_head_c),
        .full      (rx_full),
        .empty     (rx_empty)
    );

`ifdef UART_LOOPBACK_EN
    assign rx_src_c = ctrl_q[CTRL_LOOPBACK] ? tx : rx;
`else
    assign rx_src_c = rx;
`endif

    // Two-flop synchroniser on the serial input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_src_c};
        end
    end

    assign rx_in_c = rx_sync_q[1];

    // Tx framer state and line register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_cfg_q   <= '0;
            tx         <= 1'b1;
        end else begin
            tx_state_q <= tx_state_n;
            tx_s_q     <= tx_s_n;
            tx_n_q     <= tx_n_n;
            tx_b_q     <= tx_b_n;
            tx_cfg_q   <= tx_cfg_n;
            tx         <= tx_bit_n;
        end
    end

    assign tx_last_c = tx_cfg_q.dbits7 ? 3'd6 : 3'd7;

    // Tx framer next state: start, LSB-first data, stop
    always_comb begin
        tx_state_n = tx_state_q;
        tx_s_n     = tx_s_q;
        tx_n_n     = tx_n_q;
        tx_b_n     = tx_b_q;
        tx_cfg_n   = tx_cfg_q;
        tx_bit_n   = 1'b1;
        tx_pop_c   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop_c   = 1'b1;
                    tx_b_n     = tx_head_c;
                    tx_s_n     = '0;
                    tx_n_n     = '0;
                    tx_cfg_n   = cfg_c;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                tx_bit_n = 1'b0;
                if (tick_c) begin
                    if (tx_s_q == TICK_CNT_W'(OVERSAMPLE - 1)) begin
                        tx_s_n     = '0;
                        tx_state_n = ST_DATA;
                    end else begin
                        tx_s_n = tx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                tx_bit_n = tx_b_q[0];
                if (tick_c) begin
                    if (tx_s_q == TICK_CNT_W'(OVERSAMPLE - 1)) begin
                        tx_s_n = '0;
                        tx_b_n = {1'b0, tx_b_q[BYTE_W-1:1]};
                        if (tx_n_q == tx_last_c) begin
                            tx_state_n = ST_STOP;
                        end else begin
                            tx_n_n = tx_n_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        tx_s_n = tx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (tx_s_q == tx_cfg_q.stop_ticks - TICK_CNT_W'(1)) begin
                        tx_state_n = ST_IDLE;
                    end else begin
                        tx_s_n = tx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    // Rx framer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= ST_IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_cfg_q   <= '0;
        end else begin
            rx_state_q <= rx_state_n;
            rx_s_q     <= rx_s_n;
            rx_n_q     <= rx_n_n;
            rx_b_q     <= rx_b_n;
            rx_cfg_q   <= rx_cfg_n;
        end
    end

    assign rx_last_c = rx_cfg_q.dbits7 ? 3'd6 : 3'd7;
    // Bits shift in from the top, so a 7-bit word sits one place high
    assign rx_word_c = rx_cfg_q.dbits7 ? {1'b0, rx_b_q[BYTE_W-1:1]} : rx_b_q;

    // Rx framer next state: mid-bit start confirm, data sampling, stop wait
    always_comb begin
        rx_state_n = rx_state_q;
        rx_s_n     = rx_s_q;
        rx_n_n     = rx_n_q;
        rx_b_n     = rx_b_q;
        rx_cfg_n   = rx_cfg_q;
        rx_push_c  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_in_c) begin
                    rx_s_n     = '0;
                    rx_cfg_n   = cfg_c;
                    rx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (rx_s_q == TICK_CNT_W'(OVERSAMPLE / 2 - 1)) begin
                        if (!rx_in_c) begin
                            rx_s_n     = '0;
                            rx_n_n     = '0;
                            rx_state_n = ST_DATA;
                        end else begin
                            rx_state_n = ST_IDLE;
                        end
                    end else begin
                        rx_s_n = rx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (rx_s_q == TICK_CNT_W'(OVERSAMPLE - 1)) begin
                        rx_s_n = '0;
                        rx_b_n = {rx_in_c, rx_b_q[BYTE_W-1:1]};
                        if (rx_n_q == rx_last_c) begin
                            rx_state_n = ST_STOP;
                        end else begin
                            rx_n_n = rx_n_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        rx_s_n = rx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (rx_s_q == rx_cfg_q.stop_ticks - TICK_CNT_W'(1)) begin
                        rx_push_c  = 1'b1;
                        rx_state_n = ST_IDLE;
                    end else begin
                        rx_s_n = rx_s_q + TICK_CNT_W'(1);
                    end
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: tx frames and rx-FIFO reads are checked by
// monitors against queues filled by the stimulus process.
module tb_uart_core;

    localparam int DVSR      = 4;
    localparam int TICK_CLKS = DVSR + 1;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        tx;
    logic        rx;

    always #5 clk = ~clk;

    uart_core #(.FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .tx       (tx),
        .rx       (rx)
    );

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         stop_ticks;
        bit         b2b;
    } tx_exp_t;

    tx_exp_t    tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         tx_mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_word(input int dbits, input logic [1:0] stop_sel);
        logic [31:0] w;
        w = 32'(DVSR);
        w[14:13] = stop_sel;
        w[15] = (dbits == 7);
        return w;
    endfunction

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read();
        @(posedge clk); #1;
        cs = 1'b1; read = 1'b1; reg_addr = 5'd2;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input logic [7:0] exp, input int nbits,
                           input int stop_t, input bit b2b);
        tx_exp_t e;
        e.data = exp; e.nbits = nbits; e.stop_ticks = stop_t; e.b2b = b2b;
        tx_exp_q.push_back(e);
        bus_write(5'd3, {24'b0, b});
    endtask

    task automatic send_rx(input logic [7:0] b, input int nbits, input int stop_t);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int k = 0; k < nbits; k++) begin
            #1 rx = b[k];
            repeat (BIT_CLKS) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (TICK_CLKS * stop_t) @(posedge clk);
    endtask

    task automatic wait_tx_drain(input string name);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (tx_exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d tx frames outstanding at timeout, required 0", name, tx_exp_q.size());
            tx_exp_q.delete();
        end
        repeat (13 * BIT_CLKS) @(posedge clk);
    endtask

    // Tx monitor: decode each frame seen on the line and compare with the queue
    initial begin : tx_monitor
        int         prev_fall;
        int         fall;
        int         period;
        int         want;
        tx_exp_t    e;
        logic [7:0] got;
        prev_fall = 0;
        forever begin
            @(negedge clk);
            if (tx_mon_en && tx === 1'b0) begin
                fall = cyc;
                if (tx_exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: frame start at cycle %0d, required no frame", fall);
                    repeat (13 * BIT_CLKS) @(negedge clk);
                end else begin
                    e = tx_exp_q.pop_front();
                    if (e.b2b) begin
                        period = fall - prev_fall;
                        want = TICK_CLKS * (16 * (1 + e.nbits) + e.stop_ticks);
                        n_checks++;
                        if (period < want - 2 || period > want + 2) begin
                            n_errors++;
                            $display("FAIL tx_period: got %0d clocks, required %0d", period, want);
                        end
                    end
                    prev_fall = fall;
                    repeat (BIT_CLKS / 2) @(negedge clk);
                    check("tx_start", 32'(tx), 32'h0);
                    got = '0;
                    for (int k = 0; k < e.nbits; k++) begin
                        repeat (BIT_CLKS) @(negedge clk);
                        got[k] = tx;
                    end
                    check("tx_data", 32'(got), 32'(e.data));
                    repeat (BIT_CLKS) @(negedge clk);
                    check("tx_stop", 32'(tx), 32'h1);
                    repeat (TICK_CLKS * e.stop_ticks - BIT_CLKS / 2 - 2 * TICK_CLKS) @(negedge clk);
                    check("tx_stop_len", 32'(tx), 32'h1);
                end
            end
        end
    end

    // Read monitor: every RX_POP access is compared with the expected byte stream
    initial begin : rd_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (cs === 1'b1 && read === 1'b1 && reg_addr === 5'd2) begin
                if (rx_exp_q.size() != 0) begin
                    e = rx_exp_q.pop_front();
                    check("rx_data", 32'(rd_data[7:0]), 32'(e));
                    check("rx_not_empty", 32'(rd_data[8]), 32'h0);
                end else begin
                    check("rx_empty_pop", 32'(rd_data[8]), 32'h1);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin : stimulus
        bit bad;
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        reg_addr = '0; wr_data = '0; rx = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_rd_data", rd_data, 32'h0000_0100);
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("post_reset_rd_data", rd_data, 32'h0000_0100);
        tx_mon_en = 1'b1;

        // 7 data bits, 1.5 stop; bit7 of the pushed byte is not sent
        bus_write(5'd0, ctrl_word(7, 2'b01));
        push_tx(8'h33, 8'h33, 7, 24, 1'b0);
        push_tx(8'h4C, 8'h4C, 7, 24, 1'b1);
        push_tx(8'hB5, 8'h35, 7, 24, 1'b1);
        wait_tx_drain("tx_7d_1p5s");

        // 8 data bits, 2 stop
        bus_write(5'd0, ctrl_word(8, 2'b10));
        push_tx(8'hAC, 8'hAC, 8, 32, 1'b0);
        check("tx_full_after_ac", 32'(rd_data[9]), 32'h0);
        push_tx(8'h5A, 8'h5A, 8, 32, 1'b1);
        check("tx_full_after_5a", 32'(rd_data[9]), 32'h0);
        wait_tx_drain("tx_8d_2s");

        // Stop select 11 behaves as 2 stop; overfill the tx FIFO
        bus_write(5'd0, ctrl_word(8, 2'b11));
        push_tx(8'h01, 8'h01, 8, 32, 1'b0);
        push_tx(8'h80, 8'h80, 8, 32, 1'b1);
        push_tx(8'hFF, 8'hFF, 8, 32, 1'b1);
        push_tx(8'h00, 8'h00, 8, 32, 1'b1);
        push_tx(8'h69, 8'h69, 8, 32, 1'b1);
        check("tx_full_burst", 32'(rd_data[9]), 32'h1);
        bus_write(5'd3, 32'h0000_00E7);
        check("tx_full_still", 32'(rd_data[9]), 32'h1);
        wait_tx_drain("tx_burst");
        check("tx_full_drained", 32'(rd_data[9]), 32'h0);

        // Receive, 8 data, 2 stop, read after each byte
        bus_write(5'd0, ctrl_word(8, 2'b10));
        rx_exp_q.push_back(8'h32); send_rx(8'h32, 8, 32);
        repeat (10) @(posedge clk); bus_read();
        check("rx_empty_after_32", 32'(rd_data[8]), 32'h1);
        rx_exp_q.push_back(8'h57); send_rx(8'h57, 8, 32);
        repeat (10) @(posedge clk); bus_read();
        check("rx_empty_after_57", 32'(rd_data[8]), 32'h1);
        rx_exp_q.push_back(8'hA5); send_rx(8'hA5, 8, 32);
        repeat (10) @(posedge clk); bus_read();
        check("rx_empty_after_a5", 32'(rd_data[8]), 32'h1);

        // Receive, 7 data, 1.5 stop
        bus_write(5'd0, ctrl_word(7, 2'b01));
        rx_exp_q.push_back(8'h41); send_rx(8'h41, 7, 24);
        repeat (10) @(posedge clk); bus_read();
        rx_exp_q.push_back(8'h67); send_rx(8'h67, 7, 24);
        repeat (10) @(posedge clk); bus_read();
        rx_exp_q.push_back(8'h3A); send_rx(8'h3A, 7, 24);
        repeat (10) @(posedge clk); bus_read();

        // Receive, 7 data, 1 stop: fill the rx FIFO, fifth byte dropped
        bus_write(5'd0, ctrl_word(7, 2'b00));
        rx_exp_q.push_back(8'h79); send_rx(8'h79, 7, 16);
        rx_exp_q.push_back(8'h12); send_rx(8'h12, 7, 16);
        rx_exp_q.push_back(8'h6B); send_rx(8'h6B, 7, 16);
        rx_exp_q.push_back(8'h01); send_rx(8'h01, 7, 16);
        send_rx(8'h55, 7, 16);
        repeat (10) @(posedge clk); #1;
        check("rx_head_full", rd_data, 32'h0000_0079);
        for (int i = 0; i < 5; i++) bus_read();
        check("rx_empty_after_drain", 32'(rd_data[8]), 32'h1);

        // Reset in the middle of a tx frame with data in both FIFOs
        bus_write(5'd0, ctrl_word(8, 2'b00));
        send_rx(8'h5A, 8, 16);
        repeat (10) @(posedge clk); #1;
        check("rx_before_reset", rd_data, 32'h0000_005A);
        tx_mon_en = 1'b0;
        bus_write(5'd3, 32'h0);
        bus_write(5'd3, 32'h0);
        bus_write(5'd3, 32'h0);
        repeat (3 * BIT_CLKS) @(posedge clk); #1;
        check("tx_low_mid_frame", 32'(tx), 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("tx_high_on_reset", 32'(tx), 32'h1);
        check("rd_data_on_reset", rd_data, 32'h0000_0100);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 13 * BIT_CLKS; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad = 1'b1;
        end
        check("tx_idle_after_reset", 32'(bad), 32'h0);
        check("fifos_empty_after_reset", rd_data, 32'h0000_0100);

        // One-tick glitch on rx must not produce a byte
        bus_write(5'd0, ctrl_word(8, 2'b00));
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (TICK_CLKS) @(posedge clk); #1;
        rx = 1'b1;
        repeat (13 * BIT_CLKS) @(posedge clk); #1;
        check("rx_glitch_no_push", 32'(rd_data[8]), 32'h1);

        // Both directions still work after reset and glitch
        rx_exp_q.push_back(8'h3C); send_rx(8'h3C, 8, 16);
        repeat (10) @(posedge clk); bus_read();
        tx_mon_en = 1'b1;
        push_tx(8'h96, 8'h96, 8, 16, 1'b0);
        wait_tx_drain("tx_after_reset");

        n_checks++;
        if (rx_exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rx_queue_left: %0d bytes unread, required 0", rx_exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
